// File: rtl/ser_pkg.sv
// Shared types and helpers for the PISO serializer.
package ser_pkg;

   typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

   function automatic int ser_cnt_w(input int data_width);
      return $clog2(data_width);
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry holding register with full flag; in_ready is registered as ~full.
module ser_hold_reg #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  take,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  full
);

   // take is only raised while full, so it never coincides with an accept
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         full     <= 1'b0;
         in_ready <= 1'b1;
      end else if (take) begin
         full     <= 1'b0;
         in_ready <= 1'b1;
      end else if (in_valid && in_ready) begin
         out_data <= in_data;
         full     <= 1'b1;
         in_ready <= 1'b0;
      end
   end

endmodule

// File: rtl/serializer_piso_buf.sv
// Double-buffered parallel-in/serial-out shifter; chains held words without idle ticks.
module serializer_piso_buf
   import ser_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  p_valid,
   output logic                  p_ready,
   input  logic                  ser_en,
   output logic                  ser_data,
   output logic                  ser_done,
   output logic                  ser_busy
);

   localparam int CW = ser_cnt_w(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   ser_state_t            state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         bit_idx;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic                  last_tick;
   logic                  take;

   ser_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .in_data  (P_DATA),
      .in_valid (p_valid),
      .in_ready (p_ready),
      .take     (take),
      .out_data (hold_data),
      .full     (hold_full)
   );

   // hold is drained either from IDLE or on the last-bit tick for a gapless chain
   always_comb begin
      last_tick = (state == SER_SHIFT) && ser_en && (cnt == LAST);
      take      = hold_full && ((state == SER_IDLE) || last_tick);
      bit_idx   = MSB_FIRST ? (LAST - cnt) : cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SER_IDLE;
         shreg    <= '0;
         cnt      <= '0;
         ser_data <= IDLE_LEVEL;
         ser_done <= 1'b0;
         ser_busy <= 1'b0;
      end else begin
         ser_done <= 1'b0;
         case (state)
            SER_IDLE: begin
               if (ser_en) ser_data <= IDLE_LEVEL;
               if (hold_full) begin
                  shreg    <= hold_data;
                  cnt      <= '0;
                  state    <= SER_SHIFT;
                  ser_busy <= 1'b1;
               end
            end
            SER_SHIFT: begin
               if (ser_en) begin
                  ser_data <= shreg[bit_idx];
                  if (cnt == LAST) begin
                     ser_done <= 1'b1;
                     cnt      <= '0;
                     if (hold_full) begin
                        shreg <= hold_data;
                     end else begin
                        state    <= SER_IDLE;
                        ser_busy <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= SER_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serializer_piso_buf.sv
// Bench for serializer_piso_buf: three parameterisations against a bit-level reference model.
module tb_serializer_piso_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        ser_en;
   logic [2:0]  pv;
   logic [7:0]  pd0;
   logic [7:0]  pd1;
   logic [15:0] pd2;
   logic        pr   [3];
   logic        sd   [3];
   logic        sdn  [3];
   logic        sb   [3];

   always #5 clk = ~clk;

   serializer_piso_buf #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb8 (
      .clk(clk), .rst(rst), .P_DATA(pd0), .p_valid(pv[0]), .p_ready(pr[0]),
      .ser_en(ser_en), .ser_data(sd[0]), .ser_done(sdn[0]), .ser_busy(sb[0]));

   serializer_piso_buf #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb8 (
      .clk(clk), .rst(rst), .P_DATA(pd1), .p_valid(pv[1]), .p_ready(pr[1]),
      .ser_en(ser_en), .ser_data(sd[1]), .ser_done(sdn[1]), .ser_busy(sb[1]));

   serializer_piso_buf #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb16 (
      .clk(clk), .rst(rst), .P_DATA(pd2), .p_valid(pv[2]), .p_ready(pr[2]),
      .ser_en(ser_en), .ser_data(sd[2]), .ser_done(sdn[2]), .ser_busy(sb[2]));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: words and bit positions, one serial bit per tick
   int          W  [3] = '{8, 8, 16};
   bit          MS [3] = '{1'b0, 1'b1, 1'b0};
   bit          m_full [3];
   bit          m_busy [3];
   bit          m_data [3];
   bit          m_done [3];
   bit          m_ready[3];
   bit          m_acc  [3];
   logic [31:0] m_hold [3];
   logic [31:0] m_word [3];
   int          m_pos  [3];

   bit q[3][$];
   int ndone[3];

   function automatic logic [31:0] word_in(input int c);
      case (c)
         0:       return {24'd0, pd0};
         1:       return {24'd0, pd1};
         default: return {16'd0, pd2};
      endcase
   endfunction

   task automatic model_edge(input int c);
      bit acc;
      int b;
      m_acc[c] = 1'b0;
      if (rst) begin
         m_full[c]  = 1'b0;
         m_busy[c]  = 1'b0;
         m_data[c]  = 1'b1;
         m_done[c]  = 1'b0;
         m_ready[c] = 1'b1;
         m_pos[c]   = 0;
         m_word[c]  = '0;
      end else begin
         acc       = pv[c] && m_ready[c];
         m_done[c] = 1'b0;
         if (!m_busy[c]) begin
            if (ser_en) m_data[c] = 1'b1;
            if (m_full[c]) begin
               m_word[c] = m_hold[c];
               m_pos[c]  = 0;
               m_busy[c] = 1'b1;
               m_full[c] = 1'b0;
            end
         end else if (ser_en) begin
            b = MS[c] ? (W[c] - 1 - m_pos[c]) : m_pos[c];
            m_data[c] = m_word[c][b];
            m_pos[c]++;
            if (m_pos[c] == W[c]) begin
               m_done[c] = 1'b1;
               m_pos[c]  = 0;
               if (m_full[c]) begin
                  m_word[c] = m_hold[c];
                  m_full[c] = 1'b0;
               end else begin
                  m_busy[c] = 1'b0;
               end
            end
         end
         if (acc) begin
            m_full[c] = 1'b1;
            m_hold[c] = word_in(c);
            m_acc[c]  = 1'b1;
         end
         m_ready[c] = !m_full[c];
      end
   endtask

   task automatic step(input logic r, input logic en, input logic [2:0] v);
      bit pre[3];
      @(negedge clk);
      rst = r; ser_en = en; pv = v;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         pre[c] = m_busy[c] && en && !r;
         model_edge(c);
      end
      #1;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("ch%0d.ser_data", c), {31'd0, sd[c]},  {31'd0, m_data[c]});
         check($sformatf("ch%0d.ser_done", c), {31'd0, sdn[c]}, {31'd0, m_done[c]});
         check($sformatf("ch%0d.ser_busy", c), {31'd0, sb[c]},  {31'd0, m_busy[c]});
         check($sformatf("ch%0d.p_ready", c),  {31'd0, pr[c]},  {31'd0, m_ready[c]});
         if (pre[c]) q[c].push_back(sd[c]);
         if (sdn[c]) ndone[c]++;
      end
   endtask

   function automatic logic [31:0] lsb_word(input int c);
      logic [31:0] w = '0;
      for (int i = 0; i < q[c].size() && i < 32; i++) w[i] = q[c][i];
      return w;
   endfunction

   function automatic logic [31:0] msb_word(input int c);
      logic [31:0] w = '0;
      for (int i = 0; i < q[c].size(); i++) w = {w[30:0], q[c][i]};
      return w;
   endfunction

   task automatic clear_logs();
      for (int c = 0; c < 3; c++) begin
         q[c].delete();
         ndone[c] = 0;
      end
   endtask

   initial begin
      bit sent;
      bit offer;
      bit seen8;
      int busy_low;
      logic en;
      rst = 1'b1; ser_en = 1'b0; pv = '0; pd0 = '0; pd1 = '0; pd2 = '0;

      // reset and idle behaviour
      step(1'b1, 1'b0, 3'b000);
      step(1'b1, 1'b0, 3'b000);
      check("rst.ser_data", {31'd0, sd[0]}, 32'd1);
      check("rst.ser_busy", {31'd0, sb[0]}, 32'd0);
      check("rst.ser_done", {31'd0, sdn[0]}, 32'd0);
      check("rst.p_ready", {31'd0, pr[0]}, 32'd1);
      for (int k = 0; k < 8; k++) step(1'b0, k[0], 3'b000);
      check("idle.ser_data", {31'd0, sd[1]}, 32'd1);
      check("idle.ser_busy", {31'd0, sb[1]}, 32'd0);

      // 8'hD2 LSB- and MSB-first, tick every 4th clock
      clear_logs();
      seen8 = 1'b0;
      pd0 = 8'hD2; pd1 = 8'hD2;
      step(1'b0, 1'b0, 3'b011);
      for (int k = 0; k < 40; k++) begin
         step(1'b0, (k % 4) == 3, 3'b000);
         if (q[0].size() == 8 && !seen8) begin
            seen8 = 1'b1;
            check("d2.done_on_last", {31'd0, sdn[0]}, 32'd1);
            check("d2.busy_falls", {31'd0, sb[0]}, 32'd0);
         end
      end
      check("d2.lsb_bits", lsb_word(0), 32'hD2);
      check("d2.msb_bits", msb_word(1), 32'hD2);
      check("d2.nbits", q[0].size(), 32'd8);
      check("d2.ndone", ndone[0], 32'd1);
      check("d2.idle_after", {31'd0, sd[0]}, 32'd1);

      // gapless chain: 8'h0F offered during bit 3 of 8'hD2
      clear_logs();
      sent = 1'b0; offer = 1'b0; busy_low = 0;
      pd0 = 8'hD2;
      step(1'b0, 1'b0, 3'b001);
      for (int k = 0; k < 60; k++) begin
         if (q[0].size() == 3 && !sent) begin
            pd0 = 8'h0F; offer = 1'b1; sent = 1'b1;
         end
         step(1'b0, k[0], {2'b00, offer});
         if (m_acc[0]) offer = 1'b0;
         if (q[0].size() >= 1 && q[0].size() < 16 && !sb[0]) busy_low++;
      end
      check("chain.bits", lsb_word(0), 32'h0FD2);
      check("chain.nbits", q[0].size(), 32'd16);
      check("chain.ndone", ndone[0], 32'd2);
      check("chain.busy_gap", busy_low, 32'd0);
      check("chain.p_ready", {31'd0, pr[0]}, 32'd1);

      // 16-bit word with ser_en held high
      clear_logs();
      pd2 = 16'h8001;
      step(1'b0, 1'b0, 3'b100);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 3'b000);
      check("w16.bits", lsb_word(2), 32'h8001);
      check("w16.nbits", q[2].size(), 32'd16);
      check("w16.ndone", ndone[2], 32'd1);

      // reset in mid-word with a second word held
      clear_logs();
      pd0 = 8'hFF;
      step(1'b0, 1'b0, 3'b001);
      step(1'b0, 1'b0, 3'b000);
      pd0 = 8'h00;
      step(1'b0, 1'b1, 3'b001);
      step(1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b1, 3'b000);
      step(1'b1, 1'b0, 3'b000);
      check("midrst.ser_data", {31'd0, sd[0]}, 32'd1);
      check("midrst.ser_busy", {31'd0, sb[0]}, 32'd0);
      check("midrst.p_ready", {31'd0, pr[0]}, 32'd1);
      step(1'b0, 1'b0, 3'b000);
      step(1'b0, 1'b0, 3'b000);
      check("midrst.no_resume", {31'd0, sb[0]}, 32'd0);
      clear_logs();
      pd0 = 8'hAA;
      step(1'b0, 1'b0, 3'b001);
      for (int k = 0; k < 30; k++) step(1'b0, (k % 3) == 2, 3'b000);
      check("aa.bits", lsb_word(0), 32'hAA);
      check("aa.nbits", q[0].size(), 32'd8);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         pd0 = 8'($urandom);
         pd1 = 8'($urandom);
         pd2 = 16'($urandom);
         en  = ((i / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
         step($urandom_range(0, 299) == 0, en, 3'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
